// File: rtl/decoder_pkg.sv
// Shared definitions for the registered N-to-2^N decoder: mode encodings,
// controller state enum and a one-hot helper.
package decoder_pkg;

  localparam logic [1:0] DEC_MODE_HOLD  = 2'b00;
  localparam logic [1:0] DEC_MODE_PULSE = 2'b01;
  localparam logic [1:0] DEC_MODE_SCAN  = 2'b10;
  localparam logic [1:0] DEC_MODE_OFF   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HOLD  = 2'b01,
    ST_PULSE = 2'b10,
    ST_SCAN  = 2'b11
  } dec_state_t;

  // Widest supported decode is 6 bits -> 64 outputs; callers slice down.
  function automatic logic [63:0] onehot(input logic [5:0] sel);
    return 64'd1 << sel;
  endfunction

endpackage

// File: rtl/decoder_tick_cnt.sv
// Loadable down-counter that stops at zero. Used for the pulse length and
// for the scan step divider; "zero" tells the controller a period has ended.
module decoder_tick_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load has priority over counting; the count saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with valid/ready input and three
// output modes: HOLD (level), PULSE (PULSE_LEN cycles) and SCAN (walking
// one-hot, SCAN_DIV cycles per step).
// Optional feature macro: DECODER_SCAN_EN builds the SCAN state and its
// divider; without it mode 2'b10 behaves exactly like OFF.
module decoder_nto2n_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W     = 3,
  parameter int PULSE_LEN = 4,
  parameter int SCAN_DIV  = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  output logic [(2**SEL_W)-1:0] out,
  output logic                  out_valid,
  output logic [SEL_W-1:0]      out_idx
);

  localparam int OUT_W   = 2**SEL_W;
  localparam int CNT_MAX = (PULSE_LEN > SCAN_DIV) ? PULSE_LEN : SCAN_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);

  dec_state_t       state, state_n;
  logic [OUT_W-1:0] out_q, out_n;
  logic [SEL_W-1:0] idx_q, idx_n;
  logic             accept;
  logic             pulse_load, pulse_en, pulse_zero;

`ifdef DECODER_SCAN_EN
  localparam logic [CNT_W-1:0] SCAN_LOAD = CNT_W'(SCAN_DIV - 1);
  logic [SEL_W-1:0] scan_idx, scan_idx_n;
  logic             scan_load, scan_en, scan_zero;
`endif

  // Inputs are taken only in IDLE/HOLD while the mode actually decodes a
  // select; depends on state, mode and reset but never on in_valid.
  always_comb begin
    in_ready = !rst && ((state == ST_IDLE) || (state == ST_HOLD)) &&
               ((mode == DEC_MODE_HOLD) || (mode == DEC_MODE_PULSE));
  end

  assign accept    = in_valid && in_ready;
  assign out       = out_q;
  assign out_idx   = idx_q;
  assign out_valid = (out_q != '0);

  // Counts the remaining cycles of an active pulse.
  decoder_tick_cnt #(.CNT_W(CNT_W)) u_pulse_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (pulse_load),
    .en       (pulse_en),
    .load_val (PULSE_LOAD),
    .zero     (pulse_zero)
  );

`ifdef DECODER_SCAN_EN
  // Counts the cycles left on the current scan step.
  decoder_tick_cnt #(.CNT_W(CNT_W)) u_scan_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (scan_load),
    .en       (scan_en),
    .load_val (SCAN_LOAD),
    .zero     (scan_zero)
  );
`endif

  // Next-state, next-output and counter control for the mode controller.
  always_comb begin
    state_n    = state;
    out_n      = out_q;
    idx_n      = idx_q;
    pulse_load = 1'b0;
    pulse_en   = 1'b0;
`ifdef DECODER_SCAN_EN
    scan_idx_n = scan_idx;
    scan_load  = 1'b0;
    scan_en    = 1'b0;
`endif
    case (state)
      ST_IDLE, ST_HOLD: begin
        if (mode == DEC_MODE_OFF) begin
          state_n = ST_IDLE;
          out_n   = '0;
        end else if (mode == DEC_MODE_SCAN) begin
`ifdef DECODER_SCAN_EN
          state_n    = ST_SCAN;
          out_n      = OUT_W'(1);
          idx_n      = '0;
          scan_idx_n = '0;
          scan_load  = 1'b1;
`else
          state_n = ST_IDLE;
          out_n   = '0;
`endif
        end else if (accept) begin
          out_n = OUT_W'(onehot(6'(in_sel)));
          idx_n = in_sel;
          if (mode == DEC_MODE_PULSE) begin
            state_n    = ST_PULSE;
            pulse_load = 1'b1;
          end else begin
            state_n = ST_HOLD;
          end
        end
      end
      ST_PULSE: begin
        if (pulse_zero) begin
          state_n = ST_IDLE;
          out_n   = '0;
        end else begin
          pulse_en = 1'b1;
        end
      end
`ifdef DECODER_SCAN_EN
      ST_SCAN: begin
        if (mode != DEC_MODE_SCAN) begin
          state_n = ST_IDLE;
          out_n   = '0;
        end else if (scan_zero) begin
          scan_idx_n = scan_idx + SEL_W'(1);
          out_n      = OUT_W'(onehot(6'(scan_idx_n)));
          idx_n      = scan_idx_n;
          scan_load  = 1'b1;
        end else begin
          scan_en = 1'b1;
        end
      end
`endif
      default: begin
        state_n = ST_IDLE;
        out_n   = '0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      out_q <= '0;
      idx_q <= '0;
`ifdef DECODER_SCAN_EN
      scan_idx <= '0;
`endif
    end else begin
      state <= state_n;
      out_q <= out_n;
      idx_q <= idx_n;
`ifdef DECODER_SCAN_EN
      scan_idx <= scan_idx_n;
`endif
    end
  end

endmodule
